exu_wb_arbiter: RTL and testbench

//  Shares the single regfile write port between NUM_REQ execution units (upper-imm, ALU, LSU, ...).

---
 rtl/exu_wb_arbiter.sv | 115 +++++++++++
 tb/tb_exu_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wb_arbiter.sv
// Round-robin sharing of the regfile write port between NUM_REQ units through 1-entry holding buffers.
// Latency 2 cycles from acceptance to reg_wen; a unit is held off (exu_stall) while its buffer waits for a grant.
module exu_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_waddr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [AW-1:0]         reg_waddr,
  output logic                  reg_wen,
  output logic [DW-1:0]         reg_wdata,
  output logic [2:0]            grant_id,
  output logic                  exu_stall,
  output logic                  busy,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_ent_t;

  wb_ent_t              buf_q [NUM_REQ];
  logic [NUM_REQ-1:0]   buf_valid;
  logic [PW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 gnt_found;
  logic [PW-1:0]        gnt_idx;
  logic [PW:0]          sum;
  logic [PW-1:0]        idx;
  logic                 multi_pending;

  // Search starts at rr_ptr and wraps, so the last-served unit goes to the back of the line.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[PW-1:0];
      if (!gnt_found && buf_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = gnt_found && (gnt_idx == PW'(i));
    end
  end

  // A draining buffer can take a new result on the same edge.
  assign req_ready     = hrst ? '0 : (~buf_valid | grant);
  assign exu_stall     = |(req_valid & ~req_ready);
  assign busy          = (|buf_valid) | reg_wen;
  assign multi_pending = |(buf_valid & (buf_valid - NUM_REQ'(1)));

  always_ff @(posedge hclk) begin
    if (hrst) begin
      buf_valid    <= '0;
      rr_ptr       <= '0;
      reg_wen      <= 1'b0;
      reg_waddr    <= '0;
      reg_wdata    <= '0;
      grant_id     <= '0;
      conflict_cnt <= '0;
    end else begin
      reg_wen <= gnt_found;
      if (gnt_found) begin
        reg_waddr <= buf_q[gnt_idx].waddr;
        reg_wdata <= buf_q[gnt_idx].wdata;
        grant_id  <= 3'(gnt_idx);
        rr_ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
      end
      // Writes to x0 are swallowed at acceptance and never occupy a buffer.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
        if (req_valid[i] && req_ready[i]) begin
          buf_valid[i] <= (req_waddr[i*AW +: AW] != '0);
        end
      end
      if (multi_pending && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge hclk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        buf_q[i] <= {req_waddr[i*AW +: AW], req_wdata[i*DW +: DW]};
      end
    end
  end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed bench for exu_wb_arbiter: expected writes are queued at handover and matched at each reg_wen pulse.
module tb_exu_wb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int CNT_W   = 16;

  logic                  hclk = 1'b0;
  logic                  hrst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_waddr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [AW-1:0]         reg_waddr;
  logic                  reg_wen;
  logic [DW-1:0]         reg_wdata;
  logic [2:0]            grant_id;
  logic                  exu_stall;
  logic                  busy;
  logic [CNT_W-1:0]      conflict_cnt;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    g;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  exu_wb_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .hclk(hclk), .hrst(hrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .reg_waddr(reg_waddr), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
    .grant_id(grant_id), .exu_stall(exu_stall), .busy(busy),
    .conflict_cnt(conflict_cnt)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] g);
    wr_t e;
    e.a = a;
    e.d = d;
    e.g = g;
    exp_q.push_back(e);
  endtask

  // One clock; any write-port pulse is matched against the scoreboard head.
  task automatic tick;
    wr_t e;
    @(posedge hclk);
    @(negedge hclk);
    if (reg_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 64'(reg_wen), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_waddr", 64'(reg_waddr), 64'(e.a));
        chk("wb_wdata", 64'(reg_wdata), 64'(e.d));
        chk("wb_grant_id", 64'(grant_id), 64'(e.g));
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      if (exp_q.size() == 0 && reg_wen !== 1'b1) break;
      tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]    exp_rdy;
    logic [DW-1:0] d0_data;

    hrst      = 1'b1;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;

    // Reset
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_wen", 64'(reg_wen), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    hrst = 1'b0;
    #1;
    chk("rel_ready", 64'(req_ready), 64'hF);

    // Single write from unit 1
    @(negedge hclk);
    set_req(1, 5'd5, 32'h1234_5000);
    #1;
    chk("single_ready", 64'(req_ready[1]), 64'd1);
    chk("single_stall", 64'(exu_stall), 64'd0);
    expect_wr(5'd5, 32'h1234_5000, 3'd1);
    tick();
    clr_req(1);
    chk("single_lat1", 64'(reg_wen), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    chk("single_wen", 64'(reg_wen), 64'd1);
    tick();
    chk("single_once", 64'(reg_wen), 64'd0);
    chk("single_q", 64'(exp_q.size()), 64'd0);

    // Contention from a clean reset
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
      expect_wr(5'(i + 1), 32'hA000_0000 + 32'(i), 3'(i));
    end
    tick();
    for (int i = 0; i < 4; i++) clr_req(i);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_wen", 64'(reg_wen), 64'd1);
    end
    tick();
    chk("cont_idle", 64'(reg_wen), 64'd0);
    chk("cont_conflict", 64'(conflict_cnt), 64'd3);
    chk("cont_q", 64'(exp_q.size()), 64'd0);

    // Pointer back at 0: unit 0 beats unit 3
    set_req(0, 5'd7, 32'h0000_0007);
    set_req(3, 5'd8, 32'h0000_0008);
    expect_wr(5'd7, 32'h0000_0007, 3'd0);
    expect_wr(5'd8, 32'h0000_0008, 3'd3);
    tick();
    clr_req(0);
    clr_req(3);
    drain(6);
    chk("rr_conflict", 64'(conflict_cnt), 64'd4);

    // Fairness: unit 0 streams, unit 2 once; unit 0 is held off exactly one cycle
    exp_rdy = 6'b111011;
    d0_data = 32'hC000_0000;
    for (int j = 0; j < 6; j++) begin
      set_req(0, 5'd9, d0_data);
      if (j == 0) set_req(2, 5'd10, 32'hBEEF_0002);
      #1;
      chk("fair_ready0", 64'(req_ready[0]), 64'(exp_rdy[j]));
      chk("fair_stall", 64'(exu_stall), 64'(!exp_rdy[j]));
      if (exp_rdy[j]) expect_wr(5'd9, d0_data, 3'd0);
      if (j == 0) expect_wr(5'd10, 32'hBEEF_0002, 3'd2);
      tick();
      if (exp_rdy[j]) d0_data = d0_data + 32'd1;
      if (j == 0) clr_req(2);
    end
    clr_req(0);
    drain(10);
    chk("fair_conflict", 64'(conflict_cnt), 64'd6);

    // x0 destination is dropped
    set_req(3, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0_ready", 64'(req_ready[3]), 64'd1);
    tick();
    clr_req(3);
    for (int n = 0; n < 3; n++) begin
      chk("x0_busy", 64'(busy), 64'd0);
      chk("x0_wen", 64'(reg_wen), 64'd0);
      tick();
    end

    // Reset while three buffers hold results
    for (int i = 0; i < 3; i++) begin
      set_req(i, 5'(11 + i), 32'h5500_0000 + 32'(i));
      expect_wr(5'(11 + i), 32'h5500_0000 + 32'(i), 3'(i));
    end
    tick();
    for (int i = 0; i < 3; i++) clr_req(i);
    chk("mid_busy", 64'(busy), 64'd1);
    hrst = 1'b1;
    #1;
    chk("mid_ready", 64'(req_ready), 64'h0);
    tick();
    hrst = 1'b0;
    exp_q.delete();
    chk("mid_busy_after", 64'(busy), 64'd0);
    chk("mid_wen_after", 64'(reg_wen), 64'd0);
    chk("mid_conflict", 64'(conflict_cnt), 64'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("mid_no_write", 64'(reg_wen), 64'd0);
    end
    chk("final_ready", 64'(req_ready), 64'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
